ahb_ral_cmd_master: RTL

AHB-Lite master that converts a simple command stream (address, write flag, write data) into single 32-bit NONSEQ transfers. It returns one response per command. It sits directly upstream of the team's AHB RAM/register slave and drives its vc_ahb_if-style bus. It is the stimulus engine the RAL adapter and sequences use to reach RAM (0x0000–0x0FFF) and registers (0x1000+). Address and data phases are pipelined, wait states are honoured, and the two-cycle ERROR response is handled.

---
 rtl/ahb_ral_cmd_master_if.sv | 41 ++++
 rtl/ahb_ral_cmd_master.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ahb_ral_cmd_master_if.sv
// Command/response stream plus AHB-Lite master bus for ahb_ral_cmd_master.
// The master modport is the controller's view; slave is the bus/stream partner's view.
interface ahb_ral_cmd_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  hrdata, hready, hresp,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output hrdata, hready, hresp,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata
    );
endinterface

// File: rtl/ahb_ral_cmd_master.sv
// AHB-Lite master turning a command stream into single 32-bit NONSEQ transfers,
// with pipelined address/data phases, ERROR retry of the cancelled address and an FWFT response FIFO.
module ahb_ral_cmd_master #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RSP_DEPTH = 2
) (
    input logic hclk,
    input logic hreset,
    ahb_ral_cmd_master_if.master bus
);
    localparam int            PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
    localparam logic [3:0]    DEPTH_C  = 4'(RSP_DEPTH);

    typedef struct packed {
        logic          write;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic          a_vld_q, a_vld_d, a_write_q, a_write_d;
    logic [AW-1:0] a_addr_q, a_addr_d;
    logic [DW-1:0] a_wdata_q, a_wdata_d;
    logic          p_vld_q, p_vld_d, p_write_q, p_write_d;
    logic [AW-1:0] p_addr_q, p_addr_d;
    logic [DW-1:0] p_wdata_q, p_wdata_d;
    logic          d_vld_q, d_vld_d, d_write_q, d_write_d;
    logic [DW-1:0] hwdata_q, hwdata_d;
    rsp_t          mem_q [RSP_DEPTH];
    rsp_t          mem_d [RSP_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]    cnt_q, cnt_d;

    logic          err_c, addr_free, cmd_ready_c, accept, push, pop;
    logic [3:0]    inflight;
    rsp_t          push_entry, head;

    always_comb begin
        err_c       = d_vld_q && bus.hresp;
        inflight    = {3'b000, a_vld_q} + {3'b000, d_vld_q} + {3'b000, p_vld_q};
        // A cancelled address must be re-issued before any new command gets the bus.
        addr_free   = bus.hready && !p_vld_q && !(a_vld_q && err_c);
        cmd_ready_c = !hreset && ((cnt_q + inflight) < DEPTH_C) && addr_free;
        accept      = bus.cmd_valid && cmd_ready_c;
        push        = d_vld_q && bus.hready;
        pop         = (cnt_q != 4'd0) && bus.rsp_ready;

        push_entry.write = d_write_q;
        push_entry.rdata = (d_write_q || bus.hresp) ? '0 : bus.hrdata;
        push_entry.err   = bus.hresp;

        a_vld_d   = a_vld_q;
        a_write_d = a_write_q;
        a_addr_d  = a_addr_q;
        a_wdata_d = a_wdata_q;
        p_vld_d   = p_vld_q;
        p_write_d = p_write_q;
        p_addr_d  = p_addr_q;
        p_wdata_d = p_wdata_q;
        d_vld_d   = d_vld_q;
        d_write_d = d_write_q;
        hwdata_d  = hwdata_q;
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q + {3'b000, push} - {3'b000, pop};

        if (err_c && !bus.hready) begin
            // First ERROR cycle: pull back the pipelined address so the bus goes IDLE.
            if (a_vld_q) begin
                p_vld_d   = 1'b1;
                p_write_d = a_write_q;
                p_addr_d  = a_addr_q;
                p_wdata_d = a_wdata_q;
                a_vld_d   = 1'b0;
            end
        end else if (bus.hready) begin
            d_vld_d = a_vld_q;
            if (a_vld_q) begin
                d_write_d = a_write_q;
                hwdata_d  = a_wdata_q;
            end
            if (p_vld_q) begin
                a_vld_d   = 1'b1;
                a_write_d = p_write_q;
                a_addr_d  = p_addr_q;
                a_wdata_d = p_wdata_q;
                p_vld_d   = 1'b0;
            end else if (accept) begin
                a_vld_d   = 1'b1;
                a_write_d = bus.cmd_write;
                a_addr_d  = {bus.cmd_addr[AW-1:2], 2'b00};
                a_wdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
            end else begin
                a_vld_d = 1'b0;
            end
        end

        if (push) begin
            mem_d[wptr_q] = push_entry;
            wptr_d        = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            a_vld_q   <= 1'b0;
            a_write_q <= 1'b0;
            a_addr_q  <= '0;
            a_wdata_q <= '0;
            p_vld_q   <= 1'b0;
            p_write_q <= 1'b0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            d_vld_q   <= 1'b0;
            d_write_q <= 1'b0;
            hwdata_q  <= '0;
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            a_vld_q   <= a_vld_d;
            a_write_q <= a_write_d;
            a_addr_q  <= a_addr_d;
            a_wdata_q <= a_wdata_d;
            p_vld_q   <= p_vld_d;
            p_write_q <= p_write_d;
            p_addr_q  <= p_addr_d;
            p_wdata_q <= p_wdata_d;
            d_vld_q   <= d_vld_d;
            d_write_q <= d_write_d;
            hwdata_q  <= hwdata_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign head          = mem_q[rptr_q];
    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = (cnt_q != 4'd0);
    assign bus.rsp_write = bus.rsp_valid & head.write;
    assign bus.rsp_rdata = bus.rsp_valid ? head.rdata : '0;
    assign bus.rsp_err   = bus.rsp_valid & head.err;
    assign bus.hsel      = a_vld_q;
    assign bus.htrans    = a_vld_q ? 2'b10 : 2'b00;
    assign bus.haddr     = a_addr_q;
    assign bus.hwrite    = a_write_q;
    assign bus.hsize     = 3'b010;
    assign bus.hburst    = 3'b000;
    assign bus.hwdata    = hwdata_q;
endmodule
